// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared address width, reset vector and increment for the fetch PC
package pc_pkg;

  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_RESET = 32'h0;
  localparam int PC_INC = 4;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/pc_adder.sv
// rtl/pc_adder.sv - WIDTH-bit constant incrementer, wraps modulo 2^WIDTH
module pc_adder #(
  parameter int WIDTH = 32,
  parameter int INC   = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  // Carry out is intentionally dropped so the top address wraps to zero.
  assign y = a + INC_W;

endmodule

// File: rtl/pc.sv
// rtl/pc.sv - fetch program counter with branch mux and async active-low reset
module pc
  import pc_pkg::*;
#(
  parameter int              WIDTH     = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VEC = PC_RESET,
  parameter int              INC       = PC_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] PCBranch,
  output logic [WIDTH-1:0] pcaddr,
  output logic [WIDTH-1:0] pcplus4addr
);

  pc_adder #(
    .WIDTH (WIDTH),
    .INC   (INC)
  ) u_adder (
    .a (pcaddr),
    .y (pcplus4addr)
  );

  // Only an explicit 1 selects the branch; an unknown PCSrc falls through to sequential.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcaddr <= RESET_VEC;
    end else if (PCSrc == 1'b1) begin
      pcaddr <= PCBranch;
    end else begin
      pcaddr <= pcplus4addr;
    end
  end

endmodule

// File: tb/tb_pc.sv
// tb/tb_pc.sv - scoreboard bench for pc with directed and randomized branch/reset stimulus
module tb_pc;

  logic        clk;
  logic        rst;
  logic        PCSrc;
  logic [31:0] PCBranch;
  logic [31:0] pcaddr;
  logic [31:0] pcplus4addr;

  int tests;
  int failed;

  logic [31:0] ref_pc;
  logic [63:0] exp_q[$];

  pc dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrc       (PCSrc),
    .PCBranch    (PCBranch),
    .pcaddr      (pcaddr),
    .pcplus4addr (pcplus4addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after each falling edge, compare the DUT against the oldest pending expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pcaddr", pcaddr, e[63:32]);
        check("pcplus4addr", pcplus4addr, e[31:0]);
      end
    end
  end

  // One cycle of stimulus: optional held reset or a mid-cycle reset pulse, then a PC update.
  task automatic step(input logic rstv, input logic src, input logic [31:0] br, input logic pulse);
    @(negedge clk);
    #2;
    PCSrc    = src;
    PCBranch = br;
    if (!rstv) begin
      rst = 1'b0;
      #1;
      check("async_reset_pc", pcaddr, 32'h0);
      check("async_reset_plus4", pcplus4addr, 32'h4);
      ref_pc = 32'h0;
    end else begin
      if (pulse) begin
        rst = 1'b0;
        #1;
        check("pulse_reset_pc", pcaddr, 32'h0);
        ref_pc = 32'h0;
      end
      rst = 1'b1;
      ref_pc = src ? br : ref_pc + 32'd4;
    end
    exp_q.push_back({ref_pc, ref_pc + 32'd4});
  endtask

  initial begin
    int budget;
    tests    = 0;
    failed   = 0;
    ref_pc   = 32'h0;
    rst      = 1'b0;
    PCSrc    = 1'b0;
    PCBranch = 32'h0;

    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0080, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic r;
      logic s;
      logic p;
      r = ($urandom_range(0, 31) != 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 24) == 0);
      step(r, s, $urandom, p);
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
